// File: rtl/trig_readout_sequencer.sv
// trig_readout_sequencer
//   Queues trigger times and, for each one, issues a burst of NCHUNK URAM
//   read addresses starting LOOKBACK beats before the trigger time.
//
// Ports
//   memclk_i        sole clock
//   memclk_rst_i    asynchronous active-high reset
//   s_axis_tdata    trigger time (beats)        s_axis_tvalid / s_axis_tready
//   evbuf_ready_i   event buffer can take a new event (sampled only in IDLE)
//   rd_addr_o       URAM read address, qualified by rd_valid_o
//   begin_o         first beat of an event
//   event_no_o      event tag: sequence number, qualified by trig_valid_o
//   trig_time_o     event tag: unmodified trigger time
//   trig_valid_o    one-cycle strobe on the first beat
//   overflow_o      sticky, a trigger was lost or refused
//
// Build option
//   SEQ_DROP_ON_FULL_EN  defined: s_axis_tready is always 1 outside reset and
//                        triggers arriving at a full, non-popping queue are
//                        dropped (they still consume an event number).
//                        undefined: back-pressure via s_axis_tready.

module trig_readout_sequencer #(
  parameter int ADDRLEN  = 15,
  parameter int DEPTH    = 16,
  parameter int NCHUNK   = 128,
  parameter int LOOKBACK = 64,
  parameter int EVNOLEN  = 16
) (
  input  logic               memclk_i,
  input  logic               memclk_rst_i,
  input  logic [ADDRLEN-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               evbuf_ready_i,
  output logic [ADDRLEN-1:0] rd_addr_o,
  output logic               rd_valid_o,
  output logic               begin_o,
  output logic [EVNOLEN-1:0] event_no_o,
  output logic [ADDRLEN-1:0] trig_time_o,
  output logic               trig_valid_o,
  output logic               overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDRLEN-1:0] LB        = ADDRLEN'(LOOKBACK);
  localparam logic [ADDRLEN-1:0] LAST_BEAT = ADDRLEN'(NCHUNK - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t             state, state_next;

  // Queue entries carry their event number so that numbers consumed by
  // dropped triggers are skipped naturally when the entry is popped.
  logic [ADDRLEN-1:0] q_time [DEPTH];
  logic [EVNOLEN-1:0] q_evno [DEPTH];
  logic [PW:0]        wr_ptr, rd_ptr;
  logic [PW-1:0]      rd_idx;
  logic               empty, full, pop, push, drop, cnt_inc;

  logic [EVNOLEN-1:0] ev_cnt;
  logic [ADDRLEN-1:0] beat_cnt, addr_q, trig_time_q;
  logic [EVNOLEN-1:0] event_no_q;
  logic               first_q, ovf_q, last_beat;

  assign rd_idx    = rd_ptr[PW-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop       = (state == IDLE) && !empty && evbuf_ready_i;
  assign last_beat = (beat_cnt == LAST_BEAT);

`ifdef SEQ_DROP_ON_FULL_EN
  assign s_axis_tready = ~memclk_rst_i;
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign push          = s_axis_tvalid && (!full || pop);
  assign drop          = s_axis_tvalid && full && !pop;
  assign cnt_inc       = s_axis_tvalid;
`else
  assign s_axis_tready = ~memclk_rst_i & (~full | pop);
  assign push          = s_axis_tvalid & s_axis_tready;
  assign drop          = s_axis_tvalid & ~s_axis_tready;
  assign cnt_inc       = push;
`endif

  // ---- FSM state register ----
  always_ff @(posedge memclk_i or posedge memclk_rst_i) begin
    if (memclk_rst_i) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop)       state_next = READ;
      READ:    if (last_beat) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // ---- trigger queue ----
  always_ff @(posedge memclk_i) begin
    if (push) begin
      q_time[wr_ptr[PW-1:0]] <= s_axis_tdata;
      q_evno[wr_ptr[PW-1:0]] <= ev_cnt;
    end
  end

  always_ff @(posedge memclk_i or posedge memclk_rst_i) begin
    if (memclk_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ev_cnt <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (cnt_inc) ev_cnt <= ev_cnt + 1'b1;
      if (drop)    ovf_q  <= 1'b1;
    end
  end

  // ---- read address generation ----
  always_ff @(posedge memclk_i or posedge memclk_rst_i) begin
    if (memclk_rst_i) begin
      beat_cnt    <= '0;
      addr_q      <= '0;
      trig_time_q <= '0;
      event_no_q  <= '0;
      first_q     <= 1'b0;
    end else begin
      first_q <= pop;
      if (pop) begin
        // Modular subtraction: start may wrap below zero.
        addr_q      <= q_time[rd_idx] - LB;
        trig_time_q <= q_time[rd_idx];
        event_no_q  <= q_evno[rd_idx];
        beat_cnt    <= '0;
      end else if (state == READ) begin
        addr_q   <= addr_q + 1'b1;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign rd_addr_o    = addr_q;
  assign rd_valid_o   = (state == READ);
  assign begin_o      = first_q;
  assign trig_valid_o = first_q;
  assign event_no_o   = event_no_q;
  assign trig_time_o  = trig_time_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_trig_readout_sequencer.sv
module tb_trig_readout_sequencer;

  localparam int AW    = 15;
  localparam int DEPTH = 16;
  localparam int NC    = 128;
  localparam int LB    = 64;
  localparam int EW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          evbuf = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_valid, begin_s, trig_valid, overflow;
  logic [EW-1:0] event_no;
  logic [AW-1:0] trig_time;

  trig_readout_sequencer #(
    .ADDRLEN(AW), .DEPTH(DEPTH), .NCHUNK(NC), .LOOKBACK(LB), .EVNOLEN(EW)
  ) dut (
    .memclk_i      (clk),
    .memclk_rst_i  (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .evbuf_ready_i (evbuf),
    .rd_addr_o     (rd_addr),
    .rd_valid_o    (rd_valid),
    .begin_o       (begin_s),
    .event_no_o    (event_no),
    .trig_time_o   (trig_time),
    .trig_valid_o  (trig_valid),
    .overflow_o    (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a queue of pending {time, number} triggers, the event
  // being read and the number of beats it still has to deliver.
  typedef struct { logic [AW-1:0] t; logic [EW-1:0] n; } trig_t;
  trig_t         mq[$];
  trig_t         cur;
  int            rem = 0;
  logic [EW-1:0] evcnt = '0;
  logic          ovf = 1'b0;

  typedef struct { int c; logic [EW-1:0] n; } blog_t;
  blog_t blog[$];

  task automatic model_reset();
    mq.delete();
    rem   = 0;
    evcnt = '0;
    ovf   = 1'b0;
  endtask

  // One clock: check ready before the edge, advance the model on the edge,
  // check the outputs on the following falling edge.
  task automatic cycle();
    bit full, pop, rdy;
    logic [AW-1:0] ea;
    #1;
    full = (mq.size() == DEPTH);
    pop  = (rem == 0) && (mq.size() != 0) && evbuf;
`ifdef SEQ_DROP_ON_FULL_EN
    rdy = 1'b1;
`else
    rdy = !full || pop;
`endif
    chk("tready", tready, rdy);
    @(posedge clk);
    if (pop) begin
      cur = mq.pop_front();
      rem = NC;
    end else if (rem > 0) begin
      rem--;
    end
    if (tvalid) begin
      if (!full || pop) begin
        mq.push_back('{t: tdata, n: evcnt});
        evcnt++;
      end else begin
        ovf = 1'b1;
`ifdef SEQ_DROP_ON_FULL_EN
        evcnt++;
`endif
      end
    end
    cyc++;
    @(negedge clk);
    chk("rd_valid", rd_valid, rem > 0);
    chk("begin", begin_s, rem == NC);
    chk("trig_valid", trig_valid, rem == NC);
    chk("overflow", overflow, ovf);
    if (rem > 0) begin
      ea = cur.t - AW'(LB) + AW'(NC - rem);
      chk("rd_addr", rd_addr, ea);
    end
    if (rem == NC) begin
      chk("event_no", event_no, cur.n);
      chk("trig_time", trig_time, cur.t);
    end
    if (begin_s === 1'b1) blog.push_back('{c: cyc, n: event_no});
  endtask

  // Called at a falling edge; reset takes effect immediately.
  task automatic do_reset();
    tvalid = 1'b0;
    evbuf  = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_begin", begin_s, 0);
    chk("rst_trig_valid", trig_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_event_no", event_no, 0);
    chk("rst_trig_time", trig_time, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tready", tready, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_tready", tready, 1);
  endtask

  typedef struct {
    logic [AW-1:0] trig;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [EW-1:0] evno;
    logic          wrap;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [AW-1:0] prev, nxt;
    logic wrap_seen;

    vecs[0] = '{trig: 15'h0100, first: 15'h00C0, last: 15'h013F, evno: 16'd0, wrap: 1'b0};
    vecs[1] = '{trig: 15'h0010, first: 15'h7FD0, last: 15'h004F, evno: 16'd1, wrap: 1'b1};
    vecs[2] = '{trig: 15'h0040, first: 15'h0000, last: 15'h007F, evno: 16'd2, wrap: 1'b0};
    vecs[3] = '{trig: 15'h7FFF, first: 15'h7FBF, last: 15'h003E, evno: 16'd3, wrap: 1'b1};

    do_reset();

    // Single events: latency, start address, beat count, wrap.
    for (int v = 0; v < 4; v++) begin
      evbuf  = 1'b1;
      tdata  = vecs[v].trig;
      tvalid = 1'b1;
      cycle();
      tvalid = 1'b0;
      chk("lat_early", rd_valid, 0);
      cycle();
      chk("lat_begin", begin_s, 1);
      chk("vec_first", rd_addr, vecs[v].first);
      chk("vec_evno", event_no, vecs[v].evno);
      chk("vec_ttime", trig_time, vecs[v].trig);
      nb = 1;
      prev = rd_addr;
      wrap_seen = 1'b0;
      while (nb < 300) begin
        cycle();
        if (rd_valid !== 1'b1) break;
        nxt = prev + 15'd1;
        chk("vec_incr", rd_addr, nxt);
        if (prev == 15'h7FFF) wrap_seen = 1'b1;
        prev = rd_addr;
        nb++;
      end
      chk("vec_beats", nb, NC);
      chk("vec_last", prev, vecs[v].last);
      chk("vec_wrap", wrap_seen, vecs[v].wrap);
    end

    // Three back-to-back triggers.
    do_reset();
    blog.delete();
    evbuf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tdata  = AW'(15'h0200 + i * 15'h0100);
      tvalid = 1'b1;
      cycle();
    end
    tvalid = 1'b0;
    for (int k = 0; k < 3 * (NC + 1) + 20 && blog.size() < 3; k++) cycle();
    chk("b2b_count", blog.size(), 3);
    if (blog.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("b2b_evno", blog[i].n, i);
      chk("b2b_gap1", blog[1].c - blog[0].c, NC + 1);
      chk("b2b_gap2", blog[2].c - blog[1].c, NC + 1);
    end

    // Fill the queue with the event buffer stalled, then one more.
    do_reset();
    evbuf = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tdata  = AW'(i * 16'h0100);
      tvalid = 1'b1;
      if (i == 16) begin
        #1;
`ifdef SEQ_DROP_ON_FULL_EN
        chk("full_tready", tready, 1);
`else
        chk("full_tready", tready, 0);
`endif
      end
      cycle();
    end
    tvalid = 1'b0;
    chk("full_overflow", overflow, 1);
    blog.delete();
    evbuf = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    tdata  = 15'h1234;
    tvalid = 1'b1;
    cycle();
    tvalid = 1'b0;
    for (int k = 0; k < 17 * (NC + 1) + 50 && blog.size() < 17; k++) cycle();
    chk("full_count", blog.size(), 17);
    if (blog.size() == 17) begin
      for (int i = 0; i < 16; i++) chk("full_evno", blog[i].n, i);
`ifdef SEQ_DROP_ON_FULL_EN
      chk("full_next_evno", blog[16].n, 17);
`else
      chk("full_next_evno", blog[16].n, 16);
`endif
    end

    // Reset in the middle of an event.
    do_reset();
    evbuf  = 1'b1;
    tdata  = 15'h0300;
    tvalid = 1'b1;
    cycle();
    tvalid = 1'b0;
    cycle();
    chk("mid_begin", begin_s, 1);
    for (int k = 0; k < 50; k++) cycle();
    chk("mid_beat50_valid", rd_valid, 1);
    chk("mid_beat50_addr", rd_addr, 15'h0300 - 15'd64 + 15'd50);
    do_reset();
    evbuf  = 1'b1;
    tdata  = 15'h0500;
    tvalid = 1'b1;
    cycle();
    tvalid = 1'b0;
    chk("mid_after_idle", rd_valid, 0);
    cycle();
    chk("mid_after_begin", begin_s, 1);
    chk("mid_after_evno", event_no, 0);
    for (int k = 0; k < NC + 2; k++) cycle();

    // Randomised traffic against the model.
    do_reset();
    for (int k = 0; k < 5000; k++) begin
      if ((k / 400) % 3 == 1) evbuf = 1'b0;
      else                    evbuf = ($urandom_range(0, 9) < 7);
      tvalid = ($urandom_range(0, 39) == 0) || ((k / 400) % 3 == 1 && $urandom_range(0, 3) == 0);
      tdata  = AW'($urandom);
      cycle();
    end
    tvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
